// File: rtl/lstm_seq_feeder.sv
// ---------------------------------------------------------------------------
// lstm_seq_feeder
//
// Host-side initiator for the 4-step serial LSTM core. Collects four signed
// samples from a valid/ready stream into x1..x4, presents c0/h0 and pulses
// core_start for one cycle. It then waits for a rising edge on core_done and
// returns the core's C/H result on a valid/ready output port. The final state
// can optionally seed the next window's c0/h0.
//
// Optional feature macro: LSTM_FEED_TIMEOUT_EN
//   When defined, a watchdog counts clocks in WAIT. After TMO_CYCLES clocks
//   without a core_done edge it sets the sticky tmo_err flag and returns a
//   zero result. When undefined, tmo_err is tied low and WAIT only exits on
//   core_done.
//
// Ports:
//   clk, rst             clock (rising edge), async active-high reset
//   in_valid/in_data/in_ready   sample input stream
//   carry_state          1: next c0/h0 come from the accepted result, 0: zeros
//   x1..x4               window samples to the core, in arrival order
//   c0, h0               initial state to the core
//   core_start           one-cycle start pulse to the core
//   core_done            completion flag from the core (may be a level)
//   core_c, core_h       core results
//   out_valid/out_c/out_h/out_ready   result output stream
//   busy                 low only when idle in COLLECT with no sample held
//   tmo_err              sticky watchdog flag
// ---------------------------------------------------------------------------
module lstm_seq_feeder #(
    parameter int WIDTH      = 18,
    parameter int FRAC       = 11,
    parameter int TMO_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             carry_state,
    output logic [WIDTH-1:0] x1,
    output logic [WIDTH-1:0] x2,
    output logic [WIDTH-1:0] x3,
    output logic [WIDTH-1:0] x4,
    output logic [WIDTH-1:0] c0,
    output logic [WIDTH-1:0] h0,
    output logic             core_start,
    input  logic             core_done,
    input  logic [WIDTH-1:0] core_c,
    input  logic [WIDTH-1:0] core_h,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_c,
    output logic [WIDTH-1:0] out_h,
    input  logic             out_ready,
    output logic             busy,
    output logic             tmo_err
);

    // FRAC is informational only; this block keeps the parameters referenced
    // and gives an obvious place to hang elaboration checks.
    if (TMO_CYCLES < 1 || FRAC >= WIDTH) begin : g_param_chk
    end

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_START,
        ST_WAIT,
        ST_RESULT
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [1:0]       cnt_reg;
    logic [WIDTH-1:0] x_reg [4];
    logic [WIDTH-1:0] c0_reg;
    logic [WIDTH-1:0] h0_reg;
    logic [WIDTH-1:0] out_c_reg;
    logic [WIDTH-1:0] out_h_reg;
    logic             out_valid_reg;
    logic             done_q;

    // Strobes decoded by the next-state logic.
    logic accept;       // sample handshake in COLLECT
    logic enter_start;  // COLLECT -> START this cycle
    logic capture;      // core_done rising edge seen in WAIT
    logic tmo_fire;     // watchdog expiry in WAIT
    logic release_res;  // result accepted in RESULT

`ifdef LSTM_FEED_TIMEOUT_EN
    localparam int             TW       = $clog2(TMO_CYCLES + 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TMO_CYCLES - 1);
    logic [TW-1:0] tmo_cnt_reg;
    logic          tmo_err_reg;
`endif

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_COLLECT;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and strobe decode
    // -----------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        accept      = 1'b0;
        enter_start = 1'b0;
        capture     = 1'b0;
        tmo_fire    = 1'b0;
        release_res = 1'b0;
        case (state_reg)
            ST_COLLECT: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (cnt_reg == 2'd3) begin
                        enter_start = 1'b1;
                        state_next  = ST_START;
                    end
                end
            end
            ST_START: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // Edge-detect so a done level left over from the previous
                // run cannot complete this one.
                if (core_done && !done_q) begin
                    capture    = 1'b1;
                    state_next = ST_RESULT;
                end
`ifdef LSTM_FEED_TIMEOUT_EN
                else if (tmo_cnt_reg == TMO_LAST) begin
                    tmo_fire   = 1'b1;
                    state_next = ST_RESULT;
                end
`endif
            end
            ST_RESULT: begin
                if (out_ready) begin
                    release_res = 1'b1;
                    state_next  = ST_COLLECT;
                end
            end
            default: begin
                state_next = ST_COLLECT;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg       <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                x_reg[i] <= '0;
            end
            c0_reg        <= '0;
            h0_reg        <= '0;
            out_c_reg     <= '0;
            out_h_reg     <= '0;
            out_valid_reg <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            // Cleared on entry to START so the first WAIT cycle compares
            // against the done level sampled during START.
            done_q <= enter_start ? 1'b0 : core_done;

            // x registers only change in COLLECT, so they stay stable from
            // START until the result is captured. cnt wraps 3 -> 0.
            if (accept) begin
                x_reg[cnt_reg] <= in_data;
                cnt_reg        <= cnt_reg + 2'd1;
            end

            if (capture) begin
                out_c_reg     <= core_c;
                out_h_reg     <= core_h;
                out_valid_reg <= 1'b1;
            end else if (tmo_fire) begin
                // A zero result also makes the carried state zero.
                out_c_reg     <= '0;
                out_h_reg     <= '0;
                out_valid_reg <= 1'b1;
            end

            if (release_res) begin
                out_valid_reg <= 1'b0;
                c0_reg        <= carry_state ? out_c_reg : '0;
                h0_reg        <= carry_state ? out_h_reg : '0;
            end
        end
    end

`ifdef LSTM_FEED_TIMEOUT_EN
    // -----------------------------------------------------------------------
    // Watchdog: counts WAIT cycles, sticky error until reset.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_reg <= '0;
            tmo_err_reg <= 1'b0;
        end else begin
            tmo_cnt_reg <= (state_reg == ST_WAIT) ? tmo_cnt_reg + 1'b1 : '0;
            if (tmo_fire) begin
                tmo_err_reg <= 1'b1;
            end
        end
    end

    assign tmo_err = tmo_err_reg;
`else
    assign tmo_err = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign in_ready   = (state_reg == ST_COLLECT);
    assign core_start = (state_reg == ST_START);
    assign busy       = !((state_reg == ST_COLLECT) && (cnt_reg == 2'd0));
    assign x1         = x_reg[0];
    assign x2         = x_reg[1];
    assign x3         = x_reg[2];
    assign x4         = x_reg[3];
    assign c0         = c0_reg;
    assign h0         = h0_reg;
    assign out_valid  = out_valid_reg;
    assign out_c      = out_c_reg;
    assign out_h      = out_h_reg;

endmodule

// File: tb/tb_lstm_seq_feeder.sv
// ---------------------------------------------------------------------------
// tb_lstm_seq_feeder
//
// Directed-plus-random bench for lstm_seq_feeder. The bench plays both the
// sample source and a mock LSTM core, and keeps its own expectation of the
// window contents and of the carried c0/h0 state.
// ---------------------------------------------------------------------------
module tb_lstm_seq_feeder;

    localparam int W = 18;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         carry_state;
    logic [W-1:0] x1, x2, x3, x4, c0, h0;
    logic         core_start;
    logic         core_done;
    logic [W-1:0] core_c, core_h;
    logic         out_valid;
    logic [W-1:0] out_c, out_h;
    logic         out_ready;
    logic         busy;
    logic         tmo_err;

    lstm_seq_feeder #(
        .WIDTH     (W),
        .FRAC      (11),
        .TMO_CYCLES(64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .carry_state(carry_state),
        .x1         (x1),
        .x2         (x2),
        .x3         (x3),
        .x4         (x4),
        .c0         (c0),
        .h0         (h0),
        .core_start (core_start),
        .core_done  (core_done),
        .core_c     (core_c),
        .core_h     (core_h),
        .out_valid  (out_valid),
        .out_c      (out_c),
        .out_h      (out_h),
        .out_ready  (out_ready),
        .busy       (busy),
        .tmo_err    (tmo_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_starts = 0;

    // Model state: window samples and the c0/h0 the core should see next.
    logic [W-1:0] win [4];
    logic [W-1:0] exp_c0 = '0;
    logic [W-1:0] exp_h0 = '0;
    logic         exp_tmo = 1'b0;

    always @(posedge clk) begin
        if (core_start) n_starts++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_x1"}, 32'(x1), 32'd0);
        chk({tag, "_x2"}, 32'(x2), 32'd0);
        chk({tag, "_x3"}, 32'(x3), 32'd0);
        chk({tag, "_x4"}, 32'(x4), 32'd0);
        chk({tag, "_c0"}, 32'(c0), 32'd0);
        chk({tag, "_h0"}, 32'(h0), 32'd0);
        chk({tag, "_ovalid"}, 32'(out_valid), 32'd0);
        chk({tag, "_outc"}, 32'(out_c), 32'd0);
        chk({tag, "_outh"}, 32'(out_h), 32'd0);
        chk({tag, "_start"}, 32'(core_start), 32'd0);
        chk({tag, "_tmo"}, 32'(tmo_err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_iready"}, 32'(in_ready), 32'd1);
    endtask

    // Feed the four samples in win[], optionally with idle gaps, and check
    // the START cycle. Returns positioned at the first WAIT cycle.
    task automatic feed(input bit gapped, input int starts0);
        chk("idle_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = win[i];
            chk("feed_iready", 32'(in_ready), 32'd1);
            tick();
            if (i == 0) chk("busy_after_1st", 32'(busy), 32'd1);
            if (gapped && i < 3) begin
                in_valid = 1'b0;
                in_data  = W'($urandom);
                tick();
                chk("gap_start", 32'(core_start), 32'd0);
            end
        end
        in_valid = 1'b0;
        chk("start_pulse", 32'(core_start), 32'd1);
        chk("start_iready", 32'(in_ready), 32'd0);
        chk("start_x1", 32'(x1), 32'(win[0]));
        chk("start_x2", 32'(x2), 32'(win[1]));
        chk("start_x3", 32'(x3), 32'(win[2]));
        chk("start_x4", 32'(x4), 32'(win[3]));
        chk("start_c0", 32'(c0), 32'(exp_c0));
        chk("start_h0", 32'(h0), 32'(exp_h0));
        chk("start_count", 32'(n_starts - starts0), 32'd0);
        tick();
        chk("start_one_cycle", 32'(core_start), 32'd0);
        chk("wait_iready", 32'(in_ready), 32'd0);
    endtask

    // One complete window with the mock core answering after dly cycles.
    task automatic run_window(input string name, input bit gapped, input bit sticky,
                              input bit keep_done, input int dly,
                              input logic [W-1:0] rc, input logic [W-1:0] rh,
                              input int bp, input bit carry, input bit do_reset);
        int starts0;
        starts0 = n_starts;
        feed(gapped, starts0);
        if (do_reset) begin
            tick();
            tick();
            rst = 1'b1;
            #1;
            chk_reset_outputs("midrst");
            @(negedge clk);
            rst = 1'b0;
            core_done = 1'b0;
            for (int i = 0; i < 3; i++) begin
                tick();
                chk("post_rst_ovalid", 32'(out_valid), 32'd0);
                chk("post_rst_iready", 32'(in_ready), 32'd1);
            end
            exp_c0  = '0;
            exp_h0  = '0;
            exp_tmo = 1'b0;
            $display("[TB] %s: window aborted by reset in WAIT", name);
            return;
        end
        if (sticky) begin
            // done is still high from the previous run: must be ignored
            for (int i = 0; i < 3; i++) begin
                tick();
                chk("sticky_no_capture", 32'(out_valid), 32'd0);
            end
            core_done = 1'b0;
            tick();
            chk("sticky_low_no_capture", 32'(out_valid), 32'd0);
        end
        for (int i = 0; i < dly; i++) begin
            tick();
            chk("wait_ovalid", 32'(out_valid), 32'd0);
            chk("wait_no_start", 32'(core_start), 32'd0);
        end
        core_c    = rc;
        core_h    = rh;
        core_done = 1'b1;
        tick();
        chk("cap_ovalid", 32'(out_valid), 32'd1);
        chk("cap_outc", 32'(out_c), 32'(rc));
        chk("cap_outh", 32'(out_h), 32'(rh));
        chk("one_start", 32'(n_starts - starts0), 32'd1);
        if (!keep_done) core_done = 1'b0;
        core_c = W'($urandom);
        core_h = W'($urandom);
        out_ready = 1'b0;
        for (int i = 0; i < bp; i++) begin
            tick();
            chk("bp_ovalid", 32'(out_valid), 32'd1);
            chk("bp_outc", 32'(out_c), 32'(rc));
            chk("bp_outh", 32'(out_h), 32'(rh));
            chk("bp_iready", 32'(in_ready), 32'd0);
            chk("bp_no_start", 32'(core_start), 32'd0);
        end
        carry_state = carry;
        out_ready   = 1'b1;
        tick();
        out_ready   = 1'b0;
        carry_state = 1'($urandom);
        chk("acc_ovalid", 32'(out_valid), 32'd0);
        chk("acc_iready", 32'(in_ready), 32'd1);
        chk("acc_busy", 32'(busy), 32'd0);
        chk("acc_tmo", 32'(tmo_err), 32'(exp_tmo));
        chk("acc_one_start", 32'(n_starts - starts0), 32'd1);
        exp_c0 = carry ? rc : '0;
        exp_h0 = carry ? rh : '0;
        $display("[TB] %s: x=%0d,%0d,%0d,%0d c=%0d h=%0d carry=%0d bp=%0d",
                 name, win[0], win[1], win[2], win[3], rc, rh, carry, bp);
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        carry_state = 1'b0;
        core_done   = 1'b0;
        core_c      = '0;
        core_h      = '0;
        out_ready   = 1'b0;
        #12;
        @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Basic window, then carry into the next window
        win[0] = 18'd0; win[1] = 18'd1024; win[2] = 18'd512; win[3] = 18'd2048;
        run_window("basic", 1'b0, 1'b0, 1'b0, 19, 18'd3000, 18'd1500, 10, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) win[i] = W'($urandom);
        run_window("carry1", 1'b0, 1'b0, 1'b1, 5, W'($urandom), W'($urandom), 2, 1'b0, 1'b0);

        // done left high from the previous run
        for (int i = 0; i < 4; i++) win[i] = W'($urandom);
        run_window("sticky", 1'b0, 1'b1, 1'b0, 3, W'($urandom), W'($urandom), 1, 1'b1, 1'b0);

        // Gapped input with reset during WAIT, then a clean window
        for (int i = 0; i < 4; i++) win[i] = W'($urandom);
        run_window("gap_rst", 1'b1, 1'b0, 1'b0, 0, '0, '0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) win[i] = W'($urandom);
        run_window("after_rst", 1'b1, 1'b0, 1'b0, 7, W'($urandom), W'($urandom), 0, 1'b1, 1'b0);

        // Random windows
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 4; i++) win[i] = W'($urandom);
            run_window("random", 1'($urandom), 1'b0, 1'b0, int'($urandom_range(0, 40)),
                       W'($urandom), W'($urandom), int'($urandom_range(0, 6)),
                       1'($urandom), 1'b0);
        end

`ifdef LSTM_FEED_TIMEOUT_EN
        // Core never answers: watchdog returns a zero result
        begin
            int starts0;
            starts0 = n_starts;
            for (int i = 0; i < 4; i++) win[i] = W'($urandom);
            feed(1'b0, starts0);
            for (int i = 0; i < 63; i++) begin
                tick();
                chk("tmo_pending", 32'(out_valid), 32'd0);
            end
            tick();
            exp_tmo = 1'b1;
            chk("tmo_ovalid", 32'(out_valid), 32'd1);
            chk("tmo_err", 32'(tmo_err), 32'd1);
            chk("tmo_outc", 32'(out_c), 32'd0);
            chk("tmo_outh", 32'(out_h), 32'd0);
            carry_state = 1'b1;
            out_ready   = 1'b1;
            tick();
            out_ready   = 1'b0;
            chk("tmo_acc", 32'(out_valid), 32'd0);
            exp_c0 = '0;
            exp_h0 = '0;
            $display("[TB] timeout: window returned zero result");
            for (int i = 0; i < 4; i++) win[i] = W'($urandom);
            run_window("post_tmo", 1'b0, 1'b0, 1'b0, 4, W'($urandom), W'($urandom), 1, 1'b1, 1'b0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/lstm_seq_feeder.md
Name: lstm_seq_feeder

Overview:
- Host-side initiator for the 4-step serial LSTM core; it is the other end of that core's start/done handshake.
- Accepts a stream of Q7.11 samples over valid/ready and packs each group of four into x1..x4.
- Drives c0/h0, pulses core_start, waits for core_done, then returns the core's C/H result over a valid/ready output port.
- Can optionally carry the final state forward as the next window's initial state.

Parameters:
- WIDTH, 18, sample/state word width (signed two's complement).
- FRAC, 11, fractional bits (informational; no arithmetic is done on it).
- TMO_CYCLES, 1024, watchdog limit in clocks (used only with LSTM_FEED_TIMEOUT_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  sample valid.
- in_data  in  WIDTH  signed sample.
- in_ready  out  1  feeder can accept a sample.
- carry_state  in  1  1 = next window's c0/h0 come from the last result; 0 = zeros.
- x1, x2, x3, x4  out  WIDTH each  window samples to core, in arrival order.
- c0, h0  out  WIDTH each  initial state to core.
- core_start  out  1  one-cycle start pulse to core.
- core_done  in  1  core completion flag (may be level).
- core_c, core_h  in  WIDTH each  core results (c4_out, h4_out).
- out_valid  out  1  result available.
- out_c, out_h  out  WIDTH each  captured result.
- out_ready  in  1  consumer accepts result.
- busy  out  1  high in every state except COLLECT with cnt=0.
- tmo_err  out  1  sticky watchdog flag (tied 0 when the macro is off).

Behaviour:
- Reset (async): state=COLLECT, cnt=0, and all outputs are 0 (x1..x4, c0, h0, out_*, core_start, tmo_err, busy). Exception: in_ready=1.
- Reset asserted mid-operation aborts the window immediately; no result is emitted.
- State COLLECT:
  - in_ready=1.
  - Each handshake (in_valid & in_ready) writes in_data to x[cnt+1] and increments cnt.
  - The handshake with cnt=3 moves to START and resets cnt to 0.
- State START:
  - in_ready=0, core_start=1 for exactly this one cycle, then go to WAIT.
  - x1..x4, c0 and h0 are held stable from START until result capture.
- State WAIT:
  - core_done is edge-detected via a registered copy done_q, cleared to 0 on entering START.
  - On the first cycle with core_done=1 and done_q=0: capture core_c→out_c and core_h→out_h, set out_valid=1, go to RESULT.
  - A core_done that is already high at entry is ignored until it falls and rises again.
- State RESULT:
  - out_valid held with out_c/out_h stable until out_ready=1.
  - On acceptance: out_valid=0.
  - If carry_state=1 (sampled that cycle): c0←out_c, h0←out_h. Otherwise c0=h0=0.
  - Return to COLLECT.
- Latency from the 4th accepted sample: core_start asserts in the next cycle; out_valid asserts one cycle after the core_done rising edge.
- in_ready=0 in START/WAIT/RESULT: no sample overlap between windows.
- No arithmetic, saturation or sign change: values pass through bit-exact.

Optional Feature:
- Macro: LSTM_FEED_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT.
  - If TMO_CYCLES clocks elapse with no core_done edge: set tmo_err=1 (sticky until rst), set out_valid=1 with out_c=out_h=0, then enter RESULT.
  - c0/h0 are forced to 0 for the next window regardless of carry_state.
- Not defined: no counter, tmo_err tied 0, and WAIT has no exit except core_done.

Test Plan:
- Basic window: feed 0, 1024, 512, 2048 (0.0, 0.5, 0.25, 1.0) back-to-back. Mock core asserts done 20 cycles after start with c=3000, h=1500. Expect:
  - x1..x4 = 0/1024/512/2048 and c0=h0=0.
  - One core_start pulse.
  - out_valid with out_c=3000, out_h=1500, and in_ready=0 throughout.
- Backpressure: hold out_ready=0 for 10 cycles → out_valid/out_c/out_h stable for all 10, no new core_start, in_ready=0. Release → accepted in 1 cycle.
- State carry: carry_state=1, second window after result (3000, 1500) → second core_start sees c0=3000, h0=1500. Repeat with carry_state=0 → c0=h0=0.
- Sticky done: mock holds core_done=1 from the previous run through the new START → no capture until done falls and rises. The captured value is the new core_c/core_h.
- Gapped input + mid-run reset: in_valid toggles every other cycle → x registers fill in order. Assert rst during WAIT → all outputs 0, in_ready=1, no out_valid; the next window starts from x1.
- Timeout (LSTM_FEED_TIMEOUT_EN, TMO_CYCLES=64): core never asserts done → at 64 cycles tmo_err=1, out_valid=1 with out_c=out_h=0; the next window uses c0=h0=0.
